// File: rtl/uart_frame_dumper.sv
// uart_frame_dumper: streams one SDRAM-resident frame out of a built-in 8N1 UART as
// "IMG" header, pixels, optional XOR checksum (UART_DUMP_CHECKSUM_EN) and a 0x0A trailer.
module uart_frame_dumper #(
   parameter int CLK_DIV   = 434,
   parameter int IMG_W     = 320,
   parameter int IMG_H     = 240,
   parameter int PIX_BYTES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   start,
   input  logic [8*PIX_BYTES-1:0] din,
   output logic                   sdram_rd_req,
   input  logic                   sdram_read_ack,
   output logic                   busy,
   output logic                   done,
   output logic                   uart_pin
);

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [31:0] PIX_TOTAL = 32'(IMG_W) * 32'(IMG_H);
   localparam logic [1:0]  PB_LAST   = 2'(PIX_BYTES - 1);
   localparam logic [7:0]  TRAILER   = 8'h0A;
`ifdef UART_DUMP_CHECKSUM_EN
   localparam logic [7:0]  HDR_PIX   = 8'(PIX_BYTES) | 8'h80;
`else
   localparam logic [7:0]  HDR_PIX   = 8'(PIX_BYTES);
`endif

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      REQ,
      PIX,
`ifdef UART_DUMP_CHECKSUM_EN
      CSUM,
`endif
      TRL,
      DONE
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        tx_active;
   logic [15:0] tx_div;
   logic [3:0]  tx_bit;
   logic [8:0]  tx_shift;
   logic        tx_ready;
   logic        tx_load;
   logic [7:0]  tx_byte;

   logic [2:0]  hdr_idx;
   logic [1:0]  pb_idx;
   logic [31:0] pix_cnt;
   logic [31:0] pix_buf;
   logic        trl_sent;
   logic [7:0]  hdr_byte;
   logic [7:0]  pix_byte;
`ifdef UART_DUMP_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   // Ready when idle or in the last cycle of a stop bit, so back-to-back bytes have no gap.
   assign tx_ready = !tx_active || ((tx_div == DIV_LAST) && (tx_bit == 4'd9));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_active <= 1'b0;
         tx_div    <= 16'd0;
         tx_bit    <= 4'd0;
         tx_shift  <= 9'h1FF;
         uart_pin  <= 1'b1;
      end else if (tx_load) begin
         tx_active <= 1'b1;
         tx_div    <= 16'd0;
         tx_bit    <= 4'd0;
         tx_shift  <= {1'b1, tx_byte};
         uart_pin  <= 1'b0;
      end else if (tx_active) begin
         if (tx_div == DIV_LAST) begin
            tx_div <= 16'd0;
            if (tx_bit == 4'd9) begin
               tx_active <= 1'b0;
               uart_pin  <= 1'b1;
            end else begin
               tx_bit   <= tx_bit + 4'd1;
               uart_pin <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
            end
         end else begin
            tx_div <= tx_div + 16'd1;
         end
      end
   end

   always_comb begin
      case (hdr_idx)
         3'd0:    hdr_byte = 8'h49;
         3'd1:    hdr_byte = 8'h4D;
         3'd2:    hdr_byte = 8'h47;
         3'd3:    hdr_byte = 8'(IMG_W >> 8);
         3'd4:    hdr_byte = 8'(IMG_W & 255);
         3'd5:    hdr_byte = 8'(IMG_H >> 8);
         3'd6:    hdr_byte = 8'(IMG_H & 255);
         default: hdr_byte = HDR_PIX;
      endcase
   end

   assign pix_byte = pix_buf[{pb_idx, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The request is a pure decode of REQ, so it drops right after the ack edge.
   always_comb begin
      state_next   = state;
      tx_load      = 1'b0;
      tx_byte      = 8'h00;
      sdram_rd_req = 1'b0;
      case (state)
         IDLE: begin
            if (en && start) begin
               state_next = HDR;
            end
         end
         HDR: begin
            if (tx_ready) begin
               tx_load = 1'b1;
               tx_byte = hdr_byte;
               if (hdr_idx == 3'd7) begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            sdram_rd_req = 1'b1;
            if (sdram_read_ack) begin
               state_next = PIX;
            end
         end
         PIX: begin
            if (tx_ready) begin
               tx_load = 1'b1;
               tx_byte = pix_byte;
               if (pb_idx == PB_LAST) begin
                  if (pix_cnt == PIX_TOTAL - 32'd1) begin
`ifdef UART_DUMP_CHECKSUM_EN
                     state_next = CSUM;
`else
                     state_next = TRL;
`endif
                  end else begin
                     state_next = REQ;
                  end
               end
            end
         end
`ifdef UART_DUMP_CHECKSUM_EN
         CSUM: begin
            if (tx_ready) begin
               tx_load    = 1'b1;
               tx_byte    = csum;
               state_next = TRL;
            end
         end
`endif
         TRL: begin
            if (tx_ready) begin
               if (trl_sent) begin
                  state_next = DONE;
               end else begin
                  tx_load = 1'b1;
                  tx_byte = TRAILER;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   // In TRL, the second tx_ready marks the end of the trailer's stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_idx  <= 3'd0;
         pb_idx   <= 2'd0;
         pix_cnt  <= 32'd0;
         pix_buf  <= 32'd0;
         trl_sent <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
         csum     <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (en && start) begin
                  hdr_idx  <= 3'd0;
                  pb_idx   <= 2'd0;
                  pix_cnt  <= 32'd0;
                  trl_sent <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
                  csum     <= 8'h00;
`endif
               end
            end
            HDR: begin
               if (tx_load) begin
                  hdr_idx <= hdr_idx + 3'd1;
               end
            end
            REQ: begin
               if (sdram_read_ack) begin
                  pix_buf <= 32'(din);
                  pb_idx  <= 2'd0;
               end
            end
            PIX: begin
               if (tx_load) begin
`ifdef UART_DUMP_CHECKSUM_EN
                  csum <= csum ^ pix_byte;
`endif
                  if (pb_idx == PB_LAST) begin
                     pb_idx  <= 2'd0;
                     pix_cnt <= pix_cnt + 32'd1;
                  end else begin
                     pb_idx <= pb_idx + 2'd1;
                  end
               end
            end
            TRL: begin
               if (tx_load) begin
                  trl_sent <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_dumper.sv
// Directed bench for uart_frame_dumper: decodes the UART line and checks packets,
// handshake counts, timing, ignored inputs and reset mid-pixel.
`timescale 1ns/1ps
module tb_uart_frame_dumper;

   localparam int CLK_DIV   = 4;
   localparam int IMG_W     = 2;
   localparam int IMG_H     = 1;
   localparam int PIX_BYTES = 2;
   localparam int BYTE_CYC  = 10 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        start = 1'b0;
   logic        sdram_read_ack = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        sdram_rd_req;
   logic        busy;
   logic        done;
   logic        uart_pin;

   always #5 clk = ~clk;

   uart_frame_dumper #(
      .CLK_DIV  (CLK_DIV),
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .PIX_BYTES(PIX_BYTES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .start         (start),
      .din           (din),
      .sdram_rd_req  (sdram_rd_req),
      .sdram_read_ack(sdram_read_ack),
      .busy          (busy),
      .done          (done),
      .uart_pin      (uart_pin)
   );

   int checks = 0;
   int failures = 0;

   // UART receiver: samples the middle of each bit on the falling clock edge.
   logic [7:0] rxQ[$];
   logic       rxBusy = 1'b0;
   int         rxCnt = 0;
   logic [7:0] rxSh = 8'h00;
   int         frameErr = 0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxBusy <= 1'b0;
         rxCnt  <= 0;
      end else if (!rxBusy) begin
         if (uart_pin == 1'b0) begin
            rxBusy <= 1'b1;
            rxCnt  <= 1;
         end
      end else begin
         rxCnt <= rxCnt + 1;
         if (rxCnt == 9 * CLK_DIV + CLK_DIV / 2) begin
            if (uart_pin !== 1'b1) frameErr <= frameErr + 1;
            rxQ.push_back(rxSh);
            rxBusy <= 1'b0;
         end else if ((rxCnt % CLK_DIV == CLK_DIV / 2) && (rxCnt > CLK_DIV)) begin
            rxSh <= {uart_pin, rxSh[7:1]};
         end
      end
   end

   int   cycleNo = 0;
   int   reqRise = 0;
   int   doneCount = 0;
   int   doneCycle = 0;
   int   busyAtDone = 0;
   logic reqPrev = 1'b0;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   always @(negedge clk) begin
      reqPrev <= sdram_rd_req;
      if (sdram_rd_req && !reqPrev) reqRise <= reqRise + 1;
      if (done) begin
         doneCount <= doneCount + 1;
         doneCycle <= cycleNo;
         if (busy) busyAtDone <= busyAtDone + 1;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   logic [7:0] expQ[$];
   int c0;
   int base;
   int reqBase;
   int doneBase;
   int busyDoneBase;
   bit ok;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic e, input logic a, input logic [15:0] d);
      start          = s;
      en             = e;
      sdram_read_ack = a;
      din            = d;
   endtask

   task automatic startFrame(input string name);
      applyStimulus(1'b1, en, 1'b0, 16'h0000);
      c0 = cycleNo;
      @(negedge clk);
      applyStimulus(1'b0, en, 1'b0, 16'h0000);
      @(negedge clk);
      checkOutput({name, "_start_busy"}, 32'(busy), 1);
      checkOutput({name, "_start_bit"}, 32'(uart_pin), 0);
   endtask

   task automatic waitReq(output bit found);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (sdram_rd_req) found = 1'b1;
      end
      if (!found) checkOutput("req_timeout", 0, 1);
   endtask

   task automatic ackPixel(input int dly, input logic [15:0] pix);
      repeat (dly) @(negedge clk);
      if (dly > BYTE_CYC) begin
         checkOutput("slow_req_held", 32'(sdram_rd_req), 1);
         checkOutput("slow_pin_idle", 32'(uart_pin), 1);
      end
      applyStimulus(1'b0, en, 1'b1, pix);
      @(negedge clk);
      applyStimulus(1'b0, en, 1'b0, 16'h0000);
   endtask

   task automatic waitDone();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) checkOutput("done_timeout", 0, 1);
   endtask

   task automatic serveFrame(input int d0, input int d1, input logic [15:0] p0, input logic [15:0] p1);
      bit found;
      waitReq(found);
      if (!found) return;
      ackPixel(d0, p0);
      waitReq(found);
      if (!found) return;
      ackPixel(d1, p1);
      waitDone();
   endtask

   task automatic checkFrame(input int b, input string name);
      checkOutput({name, "_len"}, 32'(rxQ.size() - b), 32'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         if (b + i < rxQ.size())
            checkOutput($sformatf("%s_byte%0d", name, i), 32'(rxQ[b + i]), 32'(expQ[i]));
      end
   endtask

   initial begin
      logic [7:0] hdr7;
      hdr7 = 8'(PIX_BYTES);
`ifdef UART_DUMP_CHECKSUM_EN
      hdr7 = hdr7 | 8'h80;
`endif
      expQ = {8'h49, 8'h4D, 8'h47, 8'h00, 8'h02, 8'h00, 8'h01, hdr7,
              8'h34, 8'h12, 8'hCD, 8'hAB};
`ifdef UART_DUMP_CHECKSUM_EN
      expQ.push_back(8'h34 ^ 8'h12 ^ 8'hCD ^ 8'hAB);
`endif
      expQ.push_back(8'h0A);

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_pin", 32'(uart_pin), 1);
      checkOutput("rst_req", 32'(sdram_rd_req), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // start while en is low, then a spurious ack while idle
      base = rxQ.size();
      reqBase = reqRise;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      repeat (60) @(negedge clk);
      checkOutput("en_low_busy", 32'(busy), 0);
      checkOutput("en_low_pin", 32'(uart_pin), 1);
      checkOutput("en_low_bytes", 32'(rxQ.size() - base), 0);
      checkOutput("en_low_reqs", 32'(reqRise - reqBase), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'hEEEE);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      repeat (5) @(negedge clk);

      // Frame 1: basic frame, 3-cycle acks
      $display("[TB] frame 1: basic");
      base = rxQ.size();
      reqBase = reqRise;
      doneBase = doneCount;
      busyDoneBase = busyAtDone;
      startFrame("f1");
      serveFrame(3, 3, 16'h1234, 16'hABCD);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkFrame(base, "f1");
      checkOutput("f1_reqs", 32'(reqRise - reqBase), 2);
      checkOutput("f1_dones", 32'(doneCount - doneBase), 1);
      checkOutput("f1_latency", 32'(doneCycle - c0 - 1), 32'(1 + expQ.size() * BYTE_CYC));
      checkOutput("f1_busy_at_done", 32'(busyAtDone - busyDoneBase), 0);
      repeat (3) @(negedge clk);
      checkOutput("done_cycle_start_busy", 32'(busy), 0);
      checkOutput("done_cycle_start_pin", 32'(uart_pin), 1);

      // Frame 2: slow second ack, start and ack mid-frame, en dropped
      $display("[TB] frame 2: slow ack and ignored inputs");
      base = rxQ.size();
      reqBase = reqRise;
      doneBase = doneCount;
      startFrame("f2");
      repeat (100) @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'hEEEE);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      serveFrame(3, 100, 16'h1234, 16'hABCD);
      @(negedge clk);
      checkFrame(base, "f2");
      checkOutput("f2_reqs", 32'(reqRise - reqBase), 2);
      checkOutput("f2_dones", 32'(doneCount - doneBase), 1);

      // Frame 3: start one cycle after done, then reset during a data bit
      $display("[TB] frame 3: reset mid-pixel");
      en = 1'b1;
      startFrame("f3");
      waitReq(ok);
      if (ok) ackPixel(3, 16'h5678);
      waitReq(ok);
      repeat (5) @(negedge clk);
      checkOutput("f3_data_bit_low", 32'(uart_pin), 0);
      checkOutput("f3_req_high", 32'(sdram_rd_req), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("f3_rst_pin", 32'(uart_pin), 1);
      checkOutput("f3_rst_req", 32'(sdram_rd_req), 0);
      checkOutput("f3_rst_busy", 32'(busy), 0);
      checkOutput("f3_rst_done", 32'(done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Frame 4: full packet after reset
      $display("[TB] frame 4: after reset");
      base = rxQ.size();
      reqBase = reqRise;
      doneBase = doneCount;
      startFrame("f4");
      serveFrame(3, 3, 16'h1234, 16'hABCD);
      @(negedge clk);
      checkFrame(base, "f4");
      checkOutput("f4_reqs", 32'(reqRise - reqBase), 2);
      checkOutput("f4_dones", 32'(doneCount - doneBase), 1);
      checkOutput("f4_latency", 32'(doneCycle - c0 - 1), 32'(1 + expQ.size() * BYTE_CYC));
      checkOutput("stop_bits", 32'(frameErr), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
